// File: rtl/timetag_arbiter_if.sv
// Event-in / merged-out stream bundle for the time-tag arbiter.
// master = arbiter side; slave = event source plus downstream sink.
interface timetag_arbiter_if;
  // valid/ready on both streams: a word moves on a clk edge where valid and ready are both high.
  logic        evt_valid;
  logic [15:0] evt_data;
  logic        evt_last;
  logic        evt_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready;

  modport master (
    input  evt_valid, evt_data, evt_last, out_ready,
    output evt_ready, out_valid, out_data, out_last
  );

  modport slave (
    output evt_valid, evt_data, evt_last, out_ready,
    input  evt_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/timetag_arbiter.sv
// Merges 4-word 1 ms time-tag packets into the event stream at packet boundaries,
// latching at most one waiting time-tag and counting the ones it had to drop.
module timetag_arbiter #(
  parameter logic [15:0] TT_HEADER = 16'hF000,
  parameter int          OVR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             period_done,
  input  logic [47:0]      period,
  timetag_arbiter_if.master bus,
  output logic             tt_pending,
  output logic [OVR_W-1:0] overrun_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVT  = 2'd1,
    TT   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [47:0] shadow;
  logic [47:0] pend_period;
  logic        pending;
  logic        tt_req;
  logic        start_tt;

  assign tt_req     = enable & period_done;
  assign start_tt   = (state == IDLE) && (pending || tt_req);
  assign tt_pending = pending;
  assign dbg_state  = state;

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    bus.out_valid = 1'b0;
    bus.out_data  = 16'h0000;
    bus.out_last  = 1'b0;
    bus.evt_ready = 1'b0;
    case (state)
      IDLE: begin
        // Time-tag wins over a waiting event at a packet boundary.
        if (pending || tt_req) begin
          state_nxt = TT;
          idx_nxt   = 2'd0;
        end else if (bus.evt_valid) begin
          state_nxt = EVT;
        end
      end
      EVT: begin
        bus.out_valid = bus.evt_valid;
        bus.out_data  = bus.evt_data;
        bus.out_last  = bus.evt_last;
        bus.evt_ready = bus.out_ready;
        if (bus.evt_valid && bus.out_ready && bus.evt_last) state_nxt = IDLE;
      end
      TT: begin
        bus.out_valid = 1'b1;
        bus.out_last  = (idx == 2'd3);
        case (idx)
          2'd0:    bus.out_data = TT_HEADER;
          2'd1:    bus.out_data = shadow[47:32];
          2'd2:    bus.out_data = shadow[31:16];
          default: bus.out_data = shadow[15:0];
        endcase
        if (bus.out_ready) begin
          if (idx == 2'd3) state_nxt = IDLE;
          else             idx_nxt   = idx + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= 2'd0;
      shadow        <= 48'd0;
      pend_period   <= 48'd0;
      pending       <= 1'b0;
      overrun_count <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (start_tt) shadow <= pending ? pend_period : period;
      // Draining a pending tag while a new one arrives just refills the slot; no loss.
      if (start_tt && pending) begin
        pending <= tt_req;
        if (tt_req) pend_period <= period;
      end else if (tt_req && !start_tt) begin
        pend_period <= period;
        pending     <= 1'b1;
        if (pending && (overrun_count != '1)) overrun_count <= overrun_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_timetag_arbiter.sv
// Directed bench for timetag_arbiter: expected output words are queued as stimulus
// is driven and popped by a monitor on every output transfer.
module tb_timetag_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        period_done;
  logic [47:0] period;
  logic        tt_pending;
  logic [7:0]  overrun_count;
  logic [1:0]  dbg_state;

  timetag_arbiter_if bus ();

  timetag_arbiter #(.TT_HEADER(16'hF000), .OVR_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .period_done   (period_done),
    .period        (period),
    .bus           (bus),
    .tt_pending    (tt_pending),
    .overrun_count (overrun_count),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [16:0] exp_q[$];

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [47:0] p);
    period_done = 1'b1;
    period      = p;
    tick();
    period_done = 1'b0;
  endtask

  task automatic push_tt(input logic [47:0] p);
    exp_q.push_back({1'b0, 16'hF000});
    exp_q.push_back({1'b0, p[47:32]});
    exp_q.push_back({1'b0, p[31:16]});
    exp_q.push_back({1'b1, p[15:0]});
  endtask

  task automatic send_evt(input int n, input logic [15:0] base);
    logic acc;
    int   cnt;
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), base + 16'(i)});
    for (int i = 0; i < n; i++) begin
      bus.evt_valid = 1'b1;
      bus.evt_data  = base + 16'(i);
      bus.evt_last  = (i == n - 1);
      cnt = 0;
      do begin
        @(negedge clk);
        acc = bus.evt_ready;
        @(posedge clk);
        #1;
        cnt++;
      end while (!acc && cnt < 200);
      if (!acc) check("evt_accept_timeout", 48'(acc), 48'd1);
    end
    bus.evt_valid = 1'b0;
    bus.evt_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check("drain_queue_empty", 48'(exp_q.size()), 48'd0);
    tick();
    tick();
  endtask

  // Monitor: a word counts as transferred when valid and ready are high ahead of the edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        assert (0) else begin
          fails++;
          $error("FAIL unexpected_word: observed %0h expected none", {bus.out_last, bus.out_data});
        end
      end else begin
        check("out_word", 48'({bus.out_last, bus.out_data}), 48'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [47:0] rp;
    rst           = 1'b1;
    enable        = 1'b1;
    period_done   = 1'b0;
    period        = 48'd0;
    bus.evt_valid = 1'b0;
    bus.evt_data  = 16'h0000;
    bus.evt_last  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", 48'(bus.out_valid), 48'd0);
    check("rst_out_data", 48'(bus.out_data), 48'd0);
    check("rst_evt_ready", 48'(bus.evt_ready), 48'd0);
    check("rst_tt_pending", 48'(tt_pending), 48'd0);
    check("rst_overrun", 48'(overrun_count), 48'd0);
    check("rst_state", 48'(dbg_state), 48'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Time-tag from an idle stream, first word one cycle after the pulse.
    push_tt(48'h0000_1234_5678);
    pulse(48'h0000_1234_5678);
    check("lat_out_valid", 48'(bus.out_valid), 48'd1);
    check("lat_out_data", 48'(bus.out_data), 48'hF000);
    for (int i = 0; i < 4; i++) begin
      check("tt_evt_ready", 48'(bus.evt_ready), 48'd0);
      tick();
    end
    wait_drain();

    // Time-tag arriving mid-packet waits for the packet end.
    fork
      send_evt(6, 16'h0100);
      begin
        tick();
        tick();
        push_tt(48'd7);
        pulse(48'd7);
        check("mid_evt_tt_pending", 48'(tt_pending), 48'd1);
        check("mid_evt_state", 48'(dbg_state), 48'd1);
      end
    join
    wait_drain();

    // Back-pressure at idx1 holds the word.
    push_tt(48'h0000_1111_2222);
    pulse(48'h0000_1111_2222);
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_out_valid", 48'(bus.out_valid), 48'd1);
      check("stall_out_data", 48'(bus.out_data), 48'h0000);
      tick();
    end
    bus.out_ready = 1'b1;
    wait_drain();

    // Overrun: first starts, second pends, third overwrites.
    bus.out_ready = 1'b0;
    push_tt(48'd1);
    push_tt(48'd3);
    pulse(48'd1);
    pulse(48'd2);
    check("ovr_pending_after_2", 48'(tt_pending), 48'd1);
    check("ovr_count_after_2", 48'(overrun_count), 48'd0);
    pulse(48'd3);
    check("ovr_pending_after_3", 48'(tt_pending), 48'd1);
    check("ovr_count_after_3", 48'(overrun_count), 48'd1);
    bus.out_ready = 1'b1;
    wait_drain();
    check("ovr_pending_cleared", 48'(tt_pending), 48'd0);

    // Simultaneous event and pulse in IDLE: time-tag first, no overrun.
    push_tt(48'h0000_0000_0005);
    fork
      send_evt(3, 16'h0200);
      pulse(48'h0000_0000_0005);
    join
    wait_drain();
    check("simul_overrun", 48'(overrun_count), 48'd1);

    // Saturation of the overrun counter.
    bus.out_ready = 1'b0;
    pulse(48'hA);
    for (int i = 0; i < 300; i++) pulse(48'hB);
    check("sat_overrun", 48'(overrun_count), 48'd255);
    check("sat_state_tt", 48'(dbg_state), 48'd2);

    // Asynchronous reset in the middle of a time-tag.
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 48'(bus.out_valid), 48'd0);
    check("arst_out_data", 48'(bus.out_data), 48'd0);
    check("arst_out_last", 48'(bus.out_last), 48'd0);
    check("arst_state", 48'(dbg_state), 48'd0);
    check("arst_tt_pending", 48'(tt_pending), 48'd0);
    check("arst_overrun", 48'(overrun_count), 48'd0);
    exp_q.delete();
    tick();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    tick();

    // enable low suppresses time-tags.
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pulse(48'h100 + 48'(i));
      check("dis_tt_pending", 48'(tt_pending), 48'd0);
      check("dis_out_valid", 48'(bus.out_valid), 48'd0);
    end
    enable = 1'b1;
    tick();
    check("dis_state_idle", 48'(dbg_state), 48'd0);

    // One random period after everything else.
    rp = {16'($urandom_range(0, 16'hFFFF)), 32'($urandom)};
    push_tt(rp);
    pulse(rp);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL global_timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/timetag_arbiter.md
Name: timetag_arbiter

Overview:
- Merges 1 ms time-tag packets into the frontend event stream.
- Consumes the period timer's period_done pulse and 48-bit period count, and arbitrates a single 16-bit output stream between event packets and 4-word time-tag packets.
- Never splits an event packet. Flags time-tags that are lost because the stream is back-pressured.

Parameters:
- TT_HEADER, 16'hF000: first word of every time-tag packet.
- OVR_W, 8: width of the saturating overrun counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  when high, period_done pulses generate time-tags; when low, they are ignored
- period_done  in  1  one-cycle pulse per 1 ms period from the timer
- period  in  48  period count; valid in the cycle period_done is high
- evt_valid  in  1  event word valid
- evt_data  in  16  event word
- evt_last  in  1  final word of the event packet
- evt_ready  out  1  event word accepted
- out_valid  out  1  output word valid
- out_data  out  16  output word
- out_last  out  1  final word of the output packet
- out_ready  in  1  downstream accepts the word
- tt_pending  out  1  a time-tag is latched and not yet started
- overrun_count  out  OVR_W  number of time-tags dropped; saturating

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; pending=0; shadow and pending period regs=0.
  - out_valid=0, out_last=0, out_data=0, evt_ready=0, tt_pending=0, overrun_count=0.
- Handshakes: valid/ready on both sides; a transfer occurs when valid and ready are both high on a clk edge.
- tt_req = enable & period_done.
- Pending latch:
  - On tt_req: pend_period<=period and pending<=1, unless the same cycle starts a time-tag (IDLE->TT) directly from period.
  - If tt_req arrives while pending=1: overwrite pend_period with the new period; overrun_count+=1, saturating at all-ones.
- States:
  - IDLE:
    - out_valid=0, evt_ready=0.
    - If pending|tt_req: load shadow (pend_period if pending, else period), clear pending, go to TT with idx=0.
    - If both pending and tt_req are high: shadow<=pend_period; the new period becomes pending. This is not an overrun.
    - Else if evt_valid: go to EVT.
    - Time-tag has priority at a packet boundary.
  - EVT (combinational passthrough):
    - out_valid=evt_valid, out_data=evt_data, out_last=evt_last, evt_ready=out_ready.
    - On a transfer with evt_last=1, go to IDLE.
    - Time-tags arriving in EVT are only latched into pending.
  - TT (4 registered words, idx 0..3):
    - Words: idx0=TT_HEADER, idx1=shadow[47:32], idx2=shadow[31:16], idx3=shadow[15:0].
    - out_valid=1, evt_ready=0, out_last=(idx==3).
    - Data is held stable while out_ready=0. idx advances on each transfer.
    - On the transfer at idx3, go to IDLE.
    - tt_req during TT is latched as pending; shadow is unaffected.
- Latency:
  - Idle stream to first time-tag word on out: 1 cycle after the period_done edge.
  - There is a 1-cycle IDLE bubble between any two packets.
- tt_pending equals the pending register.
- enable low: tt_req is suppressed. An already pending or in-flight time-tag still completes.
- Overrun counter holds its value until rst. The counter never wraps.

Test Plan:
- Idle stream, out_ready=1, enable=1, period_done with period=48'h0000_1234_5678 -> next 4 cycles: out_data = F000, 0000, 1234, 5678; out_last only on the 4th word; evt_ready=0 throughout.
- 6-word event packet in progress; period_done (period=7) at word 2 -> all 6 event words pass unbroken with evt_last on word 6; tt_pending=1 from the cycle after the pulse; after one IDLE cycle, time-tag F000, 0, 0, 0007 is emitted.
- out_ready=0 for 10 cycles during TT at idx1 -> out_data holds 16'h0000 and out_valid stays 1; resumes at idx2 after out_ready rises; no word is lost or duplicated.
- out_ready=0 held; three period_done pulses with period=1, 2, 3 -> the first starts a time-tag (shadow=1), the second becomes pending, and the third overwrites pending with 3 and sets overrun_count=1; after release, the output is the time-tag for 1, then the time-tag for 3.
- evt_valid and period_done asserted in the same IDLE cycle -> the time-tag is sent first, then the event packet; no overrun.
- Force 300 overruns with OVR_W=8 -> overrun_count saturates at 255. Assert rst mid-TT -> outputs go to 0 immediately and state=IDLE. enable=0 with period_done pulses -> no time-tag and tt_pending stays 0.
